// File: rtl/perf_counter_sampler_pkg.sv
// Shared types for the perf counter sampler: sample record carried through the FIFO and sweep FSM states.
// PERF_ADDR_W is fixed by the perf_counters CSR port; sample data is carried at full 64-bit width.
package perf_counter_sampler_pkg;

   localparam int PERF_ADDR_W   = 5;
   localparam int SAMPLE_DATA_W = 64;
   localparam int SEQ_W         = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } sampler_state_e;

   typedef struct packed {
      logic [SAMPLE_DATA_W-1:0] data;
      logic [PERF_ADDR_W-1:0]   idx;
      logic [SEQ_W-1:0]         seq;
      logic                     last;
   } perf_sample_t;

endpackage

// File: rtl/perf_sample_fifo.sv
// Sample FIFO: DEPTH x perf_sample_t, push visible at head one cycle later.
// Push is ignored when full (even with a same-cycle pop); head is zero while empty.
module perf_sample_fifo
   import perf_counter_sampler_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         push_i,
   input  perf_sample_t push_dat_i,
   input  logic         pop_i,
   output perf_sample_t head_o,
   output logic         full_o,
   output logic         empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   perf_sample_t    mem_q [DEPTH];
   logic [PW-1:0]   wr_q, wr_d;
   logic [PW-1:0]   rd_q, rd_d;
   logic            push_ok;
   logic            pop_ok;

   // Extra pointer bit distinguishes full from empty when the low bits match.
   assign empty_o = (wr_q == rd_q);
   assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;
   assign wr_d    = wr_q + PW'(push_ok);
   assign rd_d    = rd_q + PW'(pop_ok);
   assign head_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

   always_ff @(posedge clk_i) begin
      if (push_ok) begin
         mem_q[wr_q[AW-1:0]] <= push_dat_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

endmodule

// File: rtl/perf_counter_sampler.sv
// Sweeps perf_counters 0..NUM_CNT-1 on timer/trigger, streaming each value out through a sample FIFO.
// One counter per cycle when the FIFO has room; a full FIFO stalls the sweep in place (no read, no clear).
module perf_counter_sampler
   import perf_counter_sampler_pkg::*;
#(
   parameter int XLEN       = 64,
   parameter int NUM_CNT    = 16,
   parameter int FIFO_DEPTH = 4,
   parameter int INTERVAL_W = 32
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   enable_i,
   input  logic [INTERVAL_W-1:0]  interval_i,
   input  logic                   trigger_i,
   input  logic                   clear_on_read_i,
   input  logic                   debug_mode_i,
   input  logic                   clr_overrun_i,
   output logic [4:0]             perf_addr_o,
   output logic                   perf_we_o,
   output logic [XLEN-1:0]        perf_data_o,
   input  logic [XLEN-1:0]        perf_data_i,
   output logic                   sample_valid_o,
   input  logic                   sample_ready_i,
   output logic [XLEN-1:0]        sample_data_o,
   output logic [4:0]             sample_idx_o,
   output logic [7:0]             sample_seq_o,
   output logic                   sample_last_o,
   output logic                   busy_o,
   output logic                   overrun_o
);

   localparam logic [PERF_ADDR_W-1:0] LAST_IDX = PERF_ADDR_W'(NUM_CNT - 1);

   sampler_state_e          state_q;
   logic [PERF_ADDR_W-1:0]  idx_q;
   logic [SEQ_W-1:0]        seq_q;
   logic                    clr_q;
   logic [INTERVAL_W-1:0]   tmr_q, tmr_d;
   logic                    ovr_q, ovr_d;

   logic                    tmr_adv;
   logic                    tmr_fire;
   logic                    req;
   logic                    accept;
   logic                    drop_busy;
   logic                    push;
   logic                    pop;
   logic                    fifo_full;
   logic                    fifo_empty;
   perf_sample_t            push_dat;
   perf_sample_t            head;

   assign tmr_adv   = enable_i && (interval_i != '0) && !debug_mode_i;
   assign tmr_fire  = tmr_adv && (tmr_q >= interval_i - INTERVAL_W'(1));
   assign req       = tmr_fire || trigger_i;
   assign accept    = req && (state_q == IDLE) && !debug_mode_i;
   assign drop_busy = req && (state_q == SWEEP);

   // The clear strobe rides only on the push cycle so each counter is read and zeroed atomically.
   assign push      = (state_q == SWEEP) && !fifo_full;
   assign pop       = sample_valid_o && sample_ready_i;

   always_comb begin
      push_dat      = '0;
      push_dat.data = SAMPLE_DATA_W'(perf_data_i);
      push_dat.idx  = idx_q;
      push_dat.seq  = seq_q;
      push_dat.last = (idx_q == LAST_IDX);
   end

   always_comb begin
      tmr_d = tmr_q;
      if (tmr_adv) begin
         tmr_d = tmr_fire ? '0 : tmr_q + INTERVAL_W'(1);
      end
      ovr_d = ovr_q;
      if (drop_busy) begin
         ovr_d = 1'b1;
      end else if (clr_overrun_i) begin
         ovr_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         idx_q   <= '0;
         seq_q   <= '0;
         clr_q   <= 1'b0;
         tmr_q   <= '0;
         ovr_q   <= 1'b0;
      end else begin
         tmr_q <= tmr_d;
         ovr_q <= ovr_d;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  state_q <= SWEEP;
                  idx_q   <= '0;
                  clr_q   <= clear_on_read_i;
               end
            end
            SWEEP: begin
               if (push) begin
                  if (idx_q == LAST_IDX) begin
                     state_q <= IDLE;
                     idx_q   <= '0;
                     seq_q   <= seq_q + SEQ_W'(1);
                  end else begin
                     idx_q   <= idx_q + PERF_ADDR_W'(1);
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   perf_sample_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .push_i     (push),
      .push_dat_i (push_dat),
      .pop_i      (pop),
      .head_o     (head),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty)
   );

   assign busy_o         = (state_q == SWEEP);
   assign perf_addr_o    = (state_q == SWEEP) ? idx_q : '0;
   assign perf_we_o      = push && clr_q;
   assign perf_data_o    = '0;
   assign overrun_o      = ovr_q;
   assign sample_valid_o = !fifo_empty;
   assign sample_data_o  = XLEN'(head.data);
   assign sample_idx_o   = head.idx;
   assign sample_seq_o   = head.seq;
   assign sample_last_o  = head.last;

endmodule

// File: tb/tb_perf_counter_sampler.sv
// Scoreboarded bench: a perf_counters model answers the CSR port, expected samples are queued per sweep.
module tb_perf_counter_sampler;

   localparam int XLEN       = 64;
   localparam int NUM_CNT    = 16;
   localparam int FIFO_DEPTH = 4;
   localparam int INTERVAL_W = 32;

   logic                  clk_i = 1'b0;
   logic                  rst_ni = 1'b0;
   logic                  enable_i = 1'b0;
   logic [INTERVAL_W-1:0] interval_i = '0;
   logic                  trigger_i = 1'b0;
   logic                  clear_on_read_i = 1'b0;
   logic                  debug_mode_i = 1'b0;
   logic                  clr_overrun_i = 1'b0;
   logic [4:0]            perf_addr_o;
   logic                  perf_we_o;
   logic [XLEN-1:0]       perf_data_o;
   logic [XLEN-1:0]       perf_data_i;
   logic                  sample_valid_o;
   logic                  sample_ready_i = 1'b0;
   logic [XLEN-1:0]       sample_data_o;
   logic [4:0]            sample_idx_o;
   logic [7:0]            sample_seq_o;
   logic                  sample_last_o;
   logic                  busy_o;
   logic                  overrun_o;

   always #5 clk_i = ~clk_i;

   perf_counter_sampler #(
      .XLEN       (XLEN),
      .NUM_CNT    (NUM_CNT),
      .FIFO_DEPTH (FIFO_DEPTH),
      .INTERVAL_W (INTERVAL_W)
   ) dut (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .enable_i        (enable_i),
      .interval_i      (interval_i),
      .trigger_i       (trigger_i),
      .clear_on_read_i (clear_on_read_i),
      .debug_mode_i    (debug_mode_i),
      .clr_overrun_i   (clr_overrun_i),
      .perf_addr_o     (perf_addr_o),
      .perf_we_o       (perf_we_o),
      .perf_data_o     (perf_data_o),
      .perf_data_i     (perf_data_i),
      .sample_valid_o  (sample_valid_o),
      .sample_ready_i  (sample_ready_i),
      .sample_data_o   (sample_data_o),
      .sample_idx_o    (sample_idx_o),
      .sample_seq_o    (sample_seq_o),
      .sample_last_o   (sample_last_o),
      .busy_o          (busy_o),
      .overrun_o       (overrun_o)
   );

   // perf_counters model: preset load, write-to-zero beats an increment in the same cycle.
   logic [63:0] cnt_mem [NUM_CNT];
   logic        load_go = 1'b0;
   logic        inc_go  = 1'b0;
   int          inc_idx = 0;

   always @(posedge clk_i) begin
      for (int i = 0; i < NUM_CNT; i++) begin
         if (load_go)                                     cnt_mem[i] <= 64'(10 * (i + 1));
         else if (perf_we_o && int'(perf_addr_o) == i)    cnt_mem[i] <= '0;
         else if (inc_go && inc_idx == i)                 cnt_mem[i] <= cnt_mem[i] + 64'd1;
      end
   end
   assign perf_data_i = cnt_mem[perf_addr_o[3:0]];

   typedef struct {
      logic [63:0] data;
      int          idx;
      int          seq;
      logic        last;
   } exp_t;

   exp_t exp_q[$];
   int   seq_m = 0;
   int   n_chk = 0;
   int   n_pass = 0;
   int   cyc = 0;
   int   busy_cnt = 0;
   int   we_cnt = 0;
   int   we_bad = 0;
   int   rise_q[$];
   logic busy_prev = 1'b0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   task automatic push_sweep();
      for (int i = 0; i < NUM_CNT; i++) begin
         exp_q.push_back('{data: cnt_mem[i], idx: i, seq: seq_m, last: (i == NUM_CNT - 1)});
      end
      seq_m = (seq_m + 1) % 256;
   endtask

   task automatic pulse_trigger();
      trigger_i = 1'b1;
      tick(1);
      trigger_i = 1'b0;
   endtask

   task automatic wait_drain(input string tag);
      int n = 0;
      while ((exp_q.size() != 0 || busy_o) && n < 3000) begin
         tick(1);
         n++;
      end
      check(tag, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic do_reset();
      enable_i   = 1'b0;
      interval_i = '0;
      rst_ni     = 1'b0;
      exp_q.delete();
      seq_m = 0;
      tick(2);
      rst_ni = 1'b1;
   endtask

   always @(posedge clk_i) cyc++;

   always @(negedge clk_i) begin
      if (rst_ni) begin
         if (sample_valid_o && sample_ready_i) begin
            if (exp_q.size() == 0) begin
               check("sb_unexpected", 64'd1, 64'd0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("smp_data", sample_data_o, e.data);
               check("smp_idx", 64'(sample_idx_o), 64'(e.idx));
               check("smp_seq", 64'(sample_seq_o), 64'(e.seq));
               check("smp_last", 64'(sample_last_o), 64'(e.last));
            end
         end
         if (busy_o) busy_cnt++;
         if (busy_o && !busy_prev) rise_q.push_back(cyc);
         if (perf_we_o) begin
            we_cnt++;
            if (perf_data_o != '0) we_bad++;
         end
      end
      busy_prev = busy_o;
   end

   initial begin
      int en_cyc;

      // Reset holds every output at zero.
      tick(2);
      check("rst_busy", 64'(busy_o), 64'd0);
      check("rst_valid", 64'(sample_valid_o), 64'd0);
      check("rst_we", 64'(perf_we_o), 64'd0);
      check("rst_addr", 64'(perf_addr_o), 64'd0);
      check("rst_ovr", 64'(overrun_o), 64'd0);
      check("rst_sdata", sample_data_o, 64'd0);
      check("rst_sidx_seq_last", 64'({sample_idx_o, sample_seq_o, sample_last_o}), 64'd0);
      check("rst_pdata", perf_data_o, 64'd0);
      rst_ni = 1'b1;
      tick(5);
      check("idle_busy", 64'(busy_o), 64'd0);
      check("idle_valid", 64'(sample_valid_o), 64'd0);

      // Triggered sweep, plain read.
      load_go = 1'b1; tick(1); load_go = 1'b0;
      sample_ready_i = 1'b1;
      busy_cnt = 0; we_cnt = 0;
      push_sweep();
      pulse_trigger();
      check("trig_busy_start", 64'(busy_o), 64'd1);
      wait_drain("trig_drain");
      check("trig_busy_cycles", 64'(busy_cnt), 64'(NUM_CNT));
      check("trig_no_we", 64'(we_cnt), 64'd0);

      // Read-and-clear; mode change mid-sweep is ignored.
      clear_on_read_i = 1'b1;
      we_cnt = 0; we_bad = 0;
      push_sweep();
      pulse_trigger();
      tick(2);
      clear_on_read_i = 1'b0;
      wait_drain("rc_drain");
      check("rc_we_cycles", 64'(we_cnt), 64'(NUM_CNT));
      check("rc_we_data_zero", 64'(we_bad), 64'd0);
      inc_idx = 2; inc_go = 1'b1; tick(3); inc_go = 1'b0;
      push_sweep();
      pulse_trigger();
      wait_drain("rc_second_drain");

      // Back-pressure: FIFO fills, sweep stalls at idx 4 without clearing.
      load_go = 1'b1; tick(1); load_go = 1'b0;
      sample_ready_i  = 1'b0;
      clear_on_read_i = 1'b1;
      we_cnt = 0;
      push_sweep();
      pulse_trigger();
      tick(12);
      check("bp_addr", 64'(perf_addr_o), 64'd4);
      check("bp_we_low", 64'(perf_we_o), 64'd0);
      check("bp_busy", 64'(busy_o), 64'd1);
      check("bp_we_count", 64'(we_cnt), 64'd4);
      check("bp_head_idx", 64'(sample_idx_o), 64'd0);
      tick(3);
      check("bp_head_stable", sample_data_o, 64'd10);
      check("bp_valid", 64'(sample_valid_o), 64'd1);
      sample_ready_i  = 1'b1;
      clear_on_read_i = 1'b0;
      wait_drain("bp_drain");
      check("bp_we_total", 64'(we_cnt), 64'(NUM_CNT));

      // Periodic timer.
      load_go = 1'b1; tick(1); load_go = 1'b0;
      rise_q.delete();
      push_sweep(); push_sweep(); push_sweep();
      interval_i = 32'd20;
      enable_i   = 1'b1;
      en_cyc     = cyc;
      tick(65);
      enable_i = 1'b0;
      wait_drain("tmr_drain");
      check("tmr_sweeps", 64'(rise_q.size()), 64'd3);
      if (rise_q.size() == 3) begin
         check("tmr_first", 64'(rise_q[0] - en_cyc), 64'd20);
         check("tmr_period1", 64'(rise_q[1] - rise_q[0]), 64'd20);
         check("tmr_period2", 64'(rise_q[2] - rise_q[1]), 64'd20);
      end

      // Overrun from a short interval, clear, and set-wins.
      do_reset();
      push_sweep();
      interval_i = 32'd3;
      enable_i   = 1'b1;
      tick(5);
      check("ovr_before", 64'(overrun_o), 64'd0);
      tick(1);
      check("ovr_set", 64'(overrun_o), 64'd1);
      tick(2);
      enable_i = 1'b0;
      wait_drain("ovr_drain");
      check("ovr_sticky", 64'(overrun_o), 64'd1);
      clr_overrun_i = 1'b1; tick(1); clr_overrun_i = 1'b0;
      check("ovr_cleared", 64'(overrun_o), 64'd0);
      push_sweep();
      pulse_trigger();
      trigger_i = 1'b1; clr_overrun_i = 1'b1;
      tick(1);
      trigger_i = 1'b0; clr_overrun_i = 1'b0;
      check("ovr_set_wins", 64'(overrun_o), 64'd1);
      wait_drain("ovr2_drain");
      clr_overrun_i = 1'b1; tick(1); clr_overrun_i = 1'b0;

      // Debug: trigger dropped without overrun, timer frozen, sweep not aborted.
      do_reset();
      debug_mode_i = 1'b1;
      pulse_trigger();
      tick(3);
      check("dbg_trig_dropped", 64'(busy_o), 64'd0);
      check("dbg_no_ovr", 64'(overrun_o), 64'd0);
      check("dbg_no_sample", 64'(sample_valid_o), 64'd0);
      interval_i = 32'd5;
      enable_i   = 1'b1;
      tick(20);
      check("dbg_timer_frozen", 64'(busy_o), 64'd0);
      push_sweep();
      debug_mode_i = 1'b0;
      tick(4);
      check("dbg_resume_wait", 64'(busy_o), 64'd0);
      tick(1);
      check("dbg_resume_fire", 64'(busy_o), 64'd1);
      enable_i = 1'b0;
      tick(2);
      debug_mode_i = 1'b1;
      wait_drain("dbg_sweep_completes");
      debug_mode_i = 1'b0;

      // Sequence number wraps 255 -> 0.
      for (int s = 0; s < 256; s++) begin
         push_sweep();
         pulse_trigger();
         wait_drain("wrap_drain");
      end

      // Reset mid-sweep abandons everything.
      sample_ready_i = 1'b0;
      push_sweep();
      pulse_trigger();
      tick(5);
      rst_ni = 1'b0;
      exp_q.delete();
      seq_m = 0;
      tick(1);
      check("midrst_busy", 64'(busy_o), 64'd0);
      check("midrst_valid", 64'(sample_valid_o), 64'd0);
      check("midrst_addr", 64'(perf_addr_o), 64'd0);
      rst_ni = 1'b1;
      tick(1);
      sample_ready_i = 1'b1;
      push_sweep();
      pulse_trigger();
      wait_drain("post_rst_drain");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
